rle_stream_encoder: RTL and testbench

Parametrised run-length encoder converting a valid/ready byte-style symbol stream into (symbol, run-length) tokens. Generalises our fixed 8-bit/4-bit compressor:
- configurable symbol and count widths;
- backpressure on both sides;
- frame termination via `in_last`;
- per-frame bypass mode.

Sits between the upstream data source and the packer/serialiser that consumes tokens.

---
 rtl/rle_stream_encoder.sv | 132 +++++++++++++
 tb/tb_rle_stream_encoder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rle_stream_encoder.sv
// Run-length encoder: turns a valid/ready symbol stream into (symbol, run, last) tokens,
// with per-frame bypass and a one-cycle DRAIN for a differing final beat.
module rle_stream_encoder #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              bypass,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_run,
  output logic              out_last,
  output logic              run_active,
  output logic [1:0]        fsm_state
);

  // Handshake: a beat/token transfers on a rising edge where valid && ready are both 1;
  // valid never waits on ready, and a presented token is held until it transfers.

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  localparam logic [CNT_W-1:0] MAX_RUN = '1;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sym_q, sym_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              out_free;
  logic              accept;
  logic              emit;
  logic [DATA_W-1:0] emit_data;
  logic [CNT_W-1:0]  emit_run;
  logic              emit_last;

  assign out_free   = !out_valid || out_ready;
  assign in_ready   = out_free && (state_q != DRAIN) && !reset;
  assign accept     = in_valid && in_ready;
  assign run_active = (state_q != IDLE);
  assign fsm_state  = state_q;

  always_comb begin
    state_d   = state_q;
    sym_d     = sym_q;
    cnt_d     = cnt_q;
    emit      = 1'b0;
    emit_data = sym_q;
    emit_run  = cnt_q;
    emit_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bypass || in_last) begin
            emit      = 1'b1;
            emit_data = in_data;
            emit_run  = ONE;
            emit_last = in_last;
          end else begin
            sym_d   = in_data;
            cnt_d   = ONE;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (accept) begin
          if (in_data == sym_q && cnt_q != MAX_RUN) begin
            if (in_last) begin
              emit      = 1'b1;
              emit_run  = cnt_q + ONE;
              emit_last = 1'b1;
              state_d   = IDLE;
            end else begin
              cnt_d = cnt_q + ONE;
            end
          end else begin
            // Close the held run; the new beat starts a fresh one (saturated or differing).
            emit    = 1'b1;
            sym_d   = in_data;
            cnt_d   = ONE;
            state_d = in_last ? DRAIN : RUN;
          end
        end
      end
      DRAIN: begin
        if (out_free) begin
          emit      = 1'b1;
          emit_run  = ONE;
          emit_last = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sym_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      cnt_q   <= cnt_d;
    end
  end

  // A new token may overwrite one that is transferring this same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_run   <= '0;
      out_last  <= 1'b0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_data  <= emit_data;
      out_run   <= emit_run;
      out_last  <= emit_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rle_stream_encoder.sv
// Bench for rle_stream_encoder: directed scenarios plus random frames under random
// backpressure, scored against a run-splitting reference model.
module tb_rle_stream_encoder;

  localparam int DATA_W  = 8;
  localparam int CNT_W   = 4;
  localparam int MAX_RUN = 15;
  localparam int TOK_W   = DATA_W + CNT_W + 1;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              bypass;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  out_run;
  logic              out_last;
  logic              run_active;
  logic [1:0]        fsm_state;

  rle_stream_encoder #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .bypass(bypass),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_run(out_run), .out_last(out_last),
    .run_active(run_active), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int               n_cmp = 0;
  int               n_err = 0;
  logic [TOK_W-1:0] exp_q[$];
  logic [DATA_W-1:0] frame[$];
  logic             rand_bp = 1'b0;
  logic             gap_en  = 1'b0;
  logic [TOK_W-1:0] cur_tok;
  logic [TOK_W-1:0] held_tok;
  logic             held = 1'b0;

  assign cur_tok = {out_data, out_run, out_last};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TOK_W-1:0] tok(input logic [DATA_W-1:0] d, input int n, input logic l);
    return {d, CNT_W'(n), l};
  endfunction

  // Reference: split the frame into maximal equal-symbol runs, chop each into MAX_RUN pieces.
  task automatic model_frame(input logic byp);
    int n = frame.size();
    int i = 0;
    int j;
    int len;
    int c;
    if (byp) begin
      for (int k = 0; k < n; k++) exp_q.push_back(tok(frame[k], 1, k == n - 1));
    end else begin
      while (i < n) begin
        j = i;
        while (j < n && frame[j] == frame[i]) j++;
        len = j - i;
        while (len > 0) begin
          c = (len > MAX_RUN) ? MAX_RUN : len;
          len -= c;
          exp_q.push_back(tok(frame[i], c, (len == 0) && (j == n)));
        end
        i = j;
      end
    end
  endtask

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("stall_valid", out_valid, 1);
        check("stall_token_hold", cur_tok, held_tok);
      end
      if (out_valid && !out_ready) begin
        check("stall_in_ready", in_ready, 0);
        held = 1'b1;
        held_tok = cur_tok;
      end else begin
        held = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $error("FAIL unexpected_token: observed %0h expected none", cur_tok);
        end else begin
          check("token", cur_tok, exp_q.pop_front());
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [DATA_W-1:0] d, input logic l);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("beat_accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic byp, input logic toggle_byp);
    int n = frame.size();
    bypass = byp;
    model_frame(byp);
    for (int i = 0; i < n; i++) begin
      if (gap_en && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_beat(frame[i], i == n - 1);
      if (toggle_byp && i == 0 && !byp && n > 1) bypass = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [DATA_W-1:0] s;
    int n;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    bypass    = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_run", out_run, 0);
    check("rst_out_last", out_last, 0);
    check("rst_run_active", run_active, 0);
    check("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // A,A,A,B(last): one DRAIN cycle between the two tokens
    frame = '{8'h41, 8'h41, 8'h41, 8'h42};
    model_frame(1'b0);
    for (int i = 0; i < 4; i++) send_beat(frame[i], i == 3);
    @(negedge clk);
    check("drain_in_ready", in_ready, 0);
    check("drain_run_active", run_active, 1);
    check("drain_first_token", cur_tok, tok(8'h41, 3, 1'b0));
    @(negedge clk);
    check("after_drain_in_ready", in_ready, 1);
    check("after_drain_run_active", run_active, 0);
    check("drain_last_token", cur_tok, tok(8'h42, 1, 1'b1));
    wait_drain();

    // 20 x 0x55: saturating split
    frame.delete();
    for (int i = 0; i < 20; i++) frame.push_back(8'h55);
    check("split_model_first", {frame.size()}, 20);
    send_frame(1'b0, 1'b0);
    wait_drain();

    // bypass frame
    frame = '{8'h10, 8'h10, 8'h11};
    send_frame(1'b1, 1'b0);
    wait_drain();
    bypass = 1'b0;

    // C,C,D with a 3-cycle output stall from the D beat, then E(last)
    frame = '{8'h43, 8'h43, 8'h44, 8'h45};
    model_frame(1'b0);
    send_beat(8'h43, 1'b0);
    send_beat(8'h43, 1'b0);
    out_ready = 1'b0;
    send_beat(8'h44, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready_low", in_ready, 0);
      check("stall_token_cc", cur_tok, tok(8'h43, 2, 1'b0));
      check("stall_out_valid", out_valid, 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_beat(8'h45, 1'b1);
    wait_drain();

    // A,A,A then asynchronous reset mid-cycle: run discarded
    send_beat(8'h41, 1'b0);
    send_beat(8'h41, 1'b0);
    send_beat(8'h41, 1'b0);
    check("pre_reset_run_active", run_active, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_run_active", run_active, 0);
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 0);
    check("async_rst_out_run", out_run, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    frame = '{8'h58};
    send_frame(1'b0, 1'b0);
    wait_drain();

    // single-beat frame: no run is ever held
    frame = '{8'h5a};
    send_frame(1'b0, 1'b0);
    @(negedge clk);
    check("single_run_active", run_active, 0);
    wait_drain();
    check("single_run_active_after", run_active, 0);

    // random frames, random gaps, random backpressure, mid-frame bypass flips
    gap_en  = 1'b1;
    rand_bp = 1'b1;
    for (int f = 0; f < 40; f++) begin
      frame.delete();
      n = $urandom_range(1, 40);
      s = DATA_W'($urandom_range(0, 2));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) s = DATA_W'($urandom_range(0, 2));
        frame.push_back(s);
      end
      send_frame($urandom_range(0, 3) == 0, 1'b1);
    end
    rand_bp = 1'b0;
    gap_en  = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
